// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte-addressed requests to a word-wide memory,
// with read-modify-write for sub-word stores and aligned/extended load data.
module load_store_unit #(
    parameter int MEM_WORDS = 1024,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [1:0]    cause_q, cause_d;

    logic          bad;
    logic          oor;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;
    logic [31:0]   merged;

    // Width/alignment legality of the incoming request
    always_comb begin
        bad = 1'b1;
        unique case (req_funct3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = req_addr[0];
            3'b010:         bad = |req_addr[1:0];
            3'b100, 3'b101: bad = req_we | (req_funct3[0] & req_addr[0]);
            default:        bad = 1'b1;
        endcase
    end

    assign oor = (req_addr >> 2) >= 32'(MEM_WORDS);

    always_comb begin
        ld_byte = mem_rdata[7:0];
        unique case (addr_q[1:0])
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext = mem_rdata;
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Sub-word store data spliced into the word just read
    always_comb begin
        merged = mem_rdata;
        if (f3_q[0]) begin
            merged = addr_q[1] ? {wdata_q[15:0], mem_rdata[15:0]}
                               : {mem_rdata[31:16], wdata_q[15:0]};
        end else begin
            unique case (addr_q[1:0])
                2'd0: merged = {mem_rdata[31:8], wdata_q[7:0]};
                2'd1: merged = {mem_rdata[31:16], wdata_q[7:0],
                                mem_rdata[7:0]};
                2'd2: merged = {mem_rdata[31:24], wdata_q[7:0],
                                mem_rdata[15:0]};
                2'd3: merged = {wdata_q[7:0], mem_rdata[23:0]};
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cause_d = 2'd0;
                    if (bad) begin
                        err_d   = 1'b1;
                        cause_d = 2'd1;
                        state_d = RESP;
                    end else if (oor) begin
                        err_d   = 1'b1;
                        cause_d = 2'd2;
                        state_d = RESP;
                    end else if (!req_we || req_funct3[1:0] != 2'b10) begin
                        state_d = RD;
                    end else begin
                        word_d  = req_wdata;
                        state_d = WR;
                    end
                end
            end
            RD: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = ld_ext;
                        state_d = RESP;
                    end else begin
                        word_d  = merged;
                        state_d = WR;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cause_d = 2'd3;
                    state_d = RESP;
                end
            end
            WR:   state_d = RESP;
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cause_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cause_q <= cause_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign mem_rd_en = (state_q == RD);
    assign mem_wr_en = (state_q == WR);
    assign mem_addr  = {2'b00, addr_q[31:2]};
    assign mem_wdata = word_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rsp_cause = cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, corner sequences
// and random traffic against a transaction-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_cause;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem  [1024];
    logic [31:0] ref_mem [1024];

    load_store_unit dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_cause(rsp_cause),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr[9:0]];

    always @(posedge clk)
        if (clk_en && mem_wr_en) tb_mem[mem_addr[9:0]] = mem_wdata;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    // Transaction-level reference: result, latency and strobe counts
    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit ready,
                         output logic [31:0] rd, output logic err,
                         output logic [1:0] cause, output int lat,
                         output int nrd, output int nwr,
                         output logic [31:0] ww);
        bit legal;
        int size, sh;
        longint unsigned word, v, m, nw;
        rd = 0; err = 0; cause = 0; lat = 0; nrd = 0; nwr = 0; ww = 0;
        legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        size = 1 << f3[1:0];
        if (!legal || (addr % size) != 0) begin
            err = 1; cause = 1; lat = 1;
        end else if (addr / 4 >= 1024) begin
            err = 1; cause = 2; lat = 1;
        end else if (we && size == 4) begin
            ref_mem[addr / 4] = wd;
            lat = 2; nwr = 1; ww = wd;
        end else if (!ready) begin
            err = 1; cause = 3; lat = 17; nrd = 16;
        end else begin
            word = longint'(ref_mem[addr / 4]);
            sh = 8 * int'(addr % 4);
            m = (64'd1 << (8 * size)) - 1;
            if (!we) begin
                v = (word >> sh) & m;
                if (f3[2] == 1'b0 && size < 4 && v >= (64'd1 << (8 * size - 1)))
                    v = v + (64'd1 << 32) - (64'd1 << (8 * size));
                rd = v[31:0];
                lat = 2; nrd = 1;
            end else begin
                m = m << sh;
                nw = (word & ~m) | ((longint'(wd) << sh) & m);
                ref_mem[addr / 4] = nw[31:0];
                ww = nw[31:0];
                lat = 3; nrd = 1; nwr = 1;
            end
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err,
                           output logic [1:0] cause, output int lat,
                           output int nrd, output int nwr,
                           output logic [31:0] ww);
        bit both;
        nrd = 0; nwr = 0; ww = 0; both = 0;
        @(negedge clk);
        chk("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            if (mem_rd_en) nrd++;
            if (mem_wr_en) begin nwr++; ww = mem_wdata; end
            if (mem_rd_en && mem_wr_en) both = 1;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_wait actual=none expected=rsp_valid");
        end
        chk("strobe_excl", 32'(both), 32'd0);
        rd = rsp_rdata; err = rsp_err; cause = rsp_cause;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [1:0]  cause;
        int          lat;
        logic [31:0] ww;
    } vec_t;

    vec_t tv [14];

    initial begin
        logic [31:0] rd, ww, erd, eww;
        logic        err, eerr;
        logic [1:0]  cause, ecause;
        int          lat, nrd, nwr, elat, enrd, enwr;
        logic [31:0] a, w;
        logic        we;
        logic [2:0]  f3;

        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        tb_mem[5] = 32'h80FF_7F01; ref_mem[5] = 32'h80FF_7F01;
        tb_mem[2] = 32'h1122_3344; ref_mem[2] = 32'h1122_3344;

        tv[0]  = '{0, 3'b000, 32'h14, 0, 32'h0000_0001, 0, 0, 2, 0};
        tv[1]  = '{0, 3'b000, 32'h17, 0, 32'hFFFF_FF80, 0, 0, 2, 0};
        tv[2]  = '{0, 3'b101, 32'h16, 0, 32'h0000_80FF, 0, 0, 2, 0};
        tv[3]  = '{0, 3'b001, 32'h16, 0, 32'hFFFF_80FF, 0, 0, 2, 0};
        tv[4]  = '{1, 3'b000, 32'h09, 32'hAB, 0, 0, 0, 3, 32'h1122_AB44};
        tv[5]  = '{0, 3'b010, 32'h08, 0, 32'h1122_AB44, 0, 0, 2, 0};
        tv[6]  = '{0, 3'b010, 32'h02, 0, 0, 1, 1, 1, 0};
        tv[7]  = '{1, 3'b001, 32'h03, 32'h55, 0, 1, 1, 1, 0};
        tv[8]  = '{0, 3'b011, 32'h00, 0, 0, 1, 1, 1, 0};
        tv[9]  = '{0, 3'b010, 32'h1000, 0, 0, 1, 2, 1, 0};
        tv[10] = '{1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 2, 32'hDEAD_BEEF};
        tv[11] = '{0, 3'b010, 32'h10, 0, 32'hDEAD_BEEF, 0, 0, 2, 0};
        tv[12] = '{0, 3'b100, 32'h17, 0, 32'h0000_0080, 0, 0, 2, 0};
        tv[13] = '{1, 3'b100, 32'h04, 32'h77, 0, 1, 1, 1, 0};

        rst = 1; clk_en = 1; req_valid = 0; req_we = 0;
        req_funct3 = 0; req_addr = 0; req_wdata = 0; mem_ready = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp", {rsp_rdata[29:0], rsp_err, 1'b0} | 32'(rsp_cause),
            32'd0);

        foreach (tv[i]) begin
            model(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd, 1'b1,
                  erd, eerr, ecause, elat, enrd, enwr, eww);
            run_req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd,
                    rd, err, cause, lat, nrd, nwr, ww);
            chk($sformatf("tv%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("tv%0d_err", i), 32'(err), 32'(tv[i].err));
            chk($sformatf("tv%0d_cause", i), 32'(cause), 32'(tv[i].cause));
            chk($sformatf("tv%0d_lat", i), 32'(lat), 32'(tv[i].lat));
            enrd = (!tv[i].err && !(tv[i].we && tv[i].f3 == 3'b010)) ? 1 : 0;
            enwr = (!tv[i].err && tv[i].we) ? 1 : 0;
            chk($sformatf("tv%0d_nrd", i), 32'(nrd), 32'(enrd));
            chk($sformatf("tv%0d_nwr", i), 32'(nwr), 32'(enwr));
            if (enwr == 1) chk($sformatf("tv%0d_wword", i), ww, tv[i].ww);
        end

        // Memory never ready: load and SB time out, SB issues no write
        mem_ready = 0;
        model(0, 3'b010, 32'h0, 0, 1'b0, erd, eerr, ecause, elat,
              enrd, enwr, eww);
        run_req(0, 3'b010, 32'h0, 0, rd, err, cause, lat, nrd, nwr, ww);
        chk("to_ld_nrd", 32'(nrd), 32'd16);
        chk("to_ld_cause", {31'd0, err} << 2 | 32'(cause), 32'h7);
        chk("to_ld_lat", 32'(lat), 32'(elat));
        model(1, 3'b000, 32'h1, 32'hEE, 1'b0, erd, eerr, ecause, elat,
              enrd, enwr, eww);
        run_req(1, 3'b000, 32'h1, 32'hEE, rd, err, cause, lat, nrd, nwr, ww);
        chk("to_sb_nwr", 32'(nwr), 32'd0);
        chk("to_sb_cause", {31'd0, err} << 2 | 32'(cause), 32'h7);
        chk("to_sb_mem", tb_mem[0], ref_mem[0]);
        mem_ready = 1;

        // Clock enable held low in RD and in RESP
        @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h14;
        @(negedge clk);
        req_valid = 0;
        clk_en = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ce_rd_hold", {30'd0, mem_rd_en, rsp_valid}, 32'd2);
        end
        clk_en = 1;
        @(negedge clk);
        chk("ce_rsp", 32'(rsp_valid), 32'd1);
        chk("ce_rdata", rsp_rdata, 32'h80FF_7F01);
        clk_en = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ce_rsp_hold", 32'(rsp_valid), 32'd1);
            chk("ce_rdata_hold", rsp_rdata, 32'h80FF_7F01);
        end
        clk_en = 1;
        @(negedge clk);
        chk("ce_done", {30'd0, rsp_valid, req_ready}, 32'd1);

        // Reset while an SB sits in WR
        req_valid = 1; req_we = 1; req_funct3 = 3'b000;
        req_addr = 32'h09; req_wdata = 32'hCD;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("rstwr_wr_en", 32'(mem_wr_en), 32'd1);
        #1 rst = 1;
        #1;
        chk("rstwr_drop", {29'd0, mem_wr_en, mem_rd_en, req_ready}, 32'd1);
        chk("rstwr_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 0;
        model(0, 3'b010, 32'h08, 0, 1'b1, erd, eerr, ecause, elat,
              enrd, enwr, eww);
        run_req(0, 3'b010, 32'h08, 0, rd, err, cause, lat, nrd, nwr, ww);
        chk("rstwr_lw", rd, erd);
        chk("rstwr_lw_ref", rd, 32'h1122_AB44);
        chk("rstwr_lw_lat", 32'(lat), 32'(elat));

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 4095)
                                            : 32'($urandom_range(0, 63));
            w = $urandom;
            model(we, f3, a, w, 1'b1, erd, eerr, ecause, elat,
                  enrd, enwr, eww);
            run_req(we, f3, a, w, rd, err, cause, lat, nrd, nwr, ww);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_err", i), {30'd0, err, 1'b0} | 32'(cause),
                {30'd0, eerr, 1'b0} | 32'(ecause));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_strb", i), 32'(nrd * 4 + nwr),
                32'(enrd * 4 + enwr));
            if (enwr == 1) chk($sformatf("rnd%0d_ww", i), ww, eww);
        end
        for (int i = 0; i < 32; i++)
            chk($sformatf("mem%0d", i), tb_mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of the data memory.
- Accepts one byte-addressed load/store request at a time from the EX/MEM pipeline register and converts it to word-indexed memory accesses.
- Performs read-modify-write for SB/SH, because the memory has no byte enables.
- Aligns and sign/zero-extends load data, detects misaligned, out-of-range and stalled accesses, and returns a one-cycle response to writeback.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in data memory; valid word index is 0..MEM_WORDS-1.
- TIMEOUT, 16, enabled cycles to wait for mem_ready in RD before faulting; must be >= 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  clock enable; all state holds when low
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  response valid for exactly one enabled cycle
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_err  out  1  access faulted
- rsp_cause  out  2  0 none, 1 misaligned/illegal funct3, 2 out of range, 3 timeout
- mem_addr  out  32  word index = latched req_addr >> 2, zero-extended
- mem_wdata  out  32  full word to write
- mem_rd_en  out  1  read strobe
- mem_wr_en  out  1  write strobe
- mem_rdata  in  32  combinational read data from memory
- mem_ready  in  1  memory read data valid

Behaviour:
- rst asserted (any time, including mid-access): state = IDLE, counter and buffers = 0, rsp_valid/rsp_err/mem_rd_en/mem_wr_en = 0, rsp_cause = 0, rsp_rdata = 0, mem_addr/mem_wdata = 0, req_ready = 1.
- All outputs decode from registered state only; there is no combinational path from req_* to mem_* or rsp_*.
- Updates occur only on clk edges with clk_en = 1. With clk_en = 0, every output holds its value, including a pending rsp_valid.
- State IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, wdata, we, funct3 and check in priority order:
    - Illegal funct3 (011, 110, 111, or 1xx with store) or misalignment (halfword with addr[0] != 0, word with addr[1:0] != 0) -> RESP, cause 1.
    - addr >> 2 >= MEM_WORDS -> RESP, cause 2.
    - Load, SB or SH -> RD.
    - SW -> WR, with mem_wdata = wdata.
- State RD:
  - mem_rd_en = 1; counter increments each enabled cycle.
  - If mem_ready: capture mem_rdata. A load goes to RESP. SB/SH merge into the captured word and go to WR.
  - SB replaces lane addr[1:0] with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; other lanes keep memory data.
  - If not ready and counter == TIMEOUT-1 -> RESP, cause 3. No write is issued.
- State WR: mem_wr_en = 1 for exactly one enabled cycle, then RESP.
- State RESP:
  - rsp_valid = 1 for one enabled cycle, then IDLE.
  - req_ready = 0 in RESP, so a new request is accepted the cycle after.
- Load extension (little-endian):
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW passes the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Latency from accept edge to rsp_valid, with mem_ready = 1:
  - Load and SW: 2 cycles (RD or WR, then RESP).
  - SB/SH: 3 cycles (RD, WR, RESP).
  - Faults detected in IDLE: 1 cycle.
- mem_rd_en and mem_wr_en are never high together.
- A faulted store never asserts mem_wr_en.

Test Plan:
- mem[5] = 0x80FF_7F01. LB addr 0x14 -> rsp_rdata 0x0000_0001. LB 0x17 -> 0xFFFF_FF80. LHU 0x16 -> 0x0000_80FF. LH 0x16 -> 0xFFFF_80FF. Each gives rsp_valid 2 cycles after accept.
- mem[2] = 0x1122_3344. SB 0x09 with wdata 0xAB -> one mem_rd_en cycle, one mem_wr_en cycle with mem_wdata 0x1122_AB44, rsp_valid 3 cycles after accept. A following LW 0x08 returns 0x1122_AB44.
- LW 0x02, SH 0x03 and funct3 011 -> rsp_err = 1, cause 1, no mem strobes. LW 0x1000 with MEM_WORDS = 1024 -> cause 2.
- Hold mem_ready = 0 during a load -> exactly 16 cycles of mem_rd_en, then rsp_err = 1 with cause 3. For SB under the same condition, mem_wr_en never asserts.
- Toggle clk_en low for 3 cycles during RD and during RESP -> state, strobes and rsp_valid hold. The response still arrives after the same number of enabled cycles.
- Assert rst during WR of an SB -> mem_wr_en drops immediately and state returns to IDLE with req_ready = 1. The next LW completes normally.
